// File: rtl/apb_cmd_pkg.sv
// Shared types for the APB command master: transfer FSM states and register map indices.
package apb_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  typedef enum logic [3:0] {
    internal_status_reg = 4'd0,
    control_reg         = 4'd1,
    cent_1_reg          = 4'd2,
    cent_2_reg          = 4'd3,
    cent_3_reg          = 4'd4,
    cent_4_reg          = 4'd5,
    cent_5_reg          = 4'd6,
    cent_6_reg          = 4'd7,
    cent_7_reg          = 4'd8,
    cent_8_reg          = 4'd9,
    data_in_reg         = 4'd10,
    data_out_reg        = 4'd11,
    first_ram_addr_reg  = 4'd12,
    last_ram_addr_reg   = 4'd13
  } reg_idx_e;

endpackage

// File: rtl/apb_cmd_fifo.sv
// Small synchronous FIFO for buffered APB commands. Besides the head it exposes the entry
// that becomes the head after a pop this cycle, so the master can start the next transfer
// without a bubble.
module apb_cmd_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [Width-1:0] head_o,
  output logic             next_valid_o,
  output logic [Width-1:0] next_data_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] LastPtr  = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);
  localparam logic [CntW-1:0] OneCnt   = CntW'(1);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]  rd_ptr_inc;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok, pop_ok;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  assign full_o     = (count_q == DepthCnt);
  assign empty_o    = (count_q == '0);
  assign push_ok    = push_i && !full_o;
  assign pop_ok     = pop_i && !empty_o;
  assign rd_ptr_inc = ptr_inc(rd_ptr_q);
  assign head_o     = mem_q[rd_ptr_q];

  // Head after a pop: second stored entry, or the word being pushed through right now.
  assign next_valid_o = (count_q > OneCnt) || push_ok;
  assign next_data_o  = (count_q > OneCnt) ? mem_q[rd_ptr_inc] : push_data_i;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_inc;
    end
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers; reset empties the buffer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Data storage needs no reset; occupancy tracking decides what is valid.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/apb_cmd_master.sv
// APB requester driven from a buffered command stream, with access timeout and a sticky
// interrupt capture flag.
module apb_cmd_master
  import apb_cmd_pkg::*;
#(
  parameter int unsigned addrWidth      = 9,
  parameter int unsigned dataWidth      = 91,
  parameter int unsigned fifo_depth     = 2,
  parameter int unsigned timeout_cycles = 255,
  parameter int unsigned to_width       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [addrWidth-1:0] cmd_addr,
  input  logic [dataWidth-1:0] cmd_wdata,
  output logic                 rsp_valid,
  output logic [dataWidth-1:0] rsp_rdata,
  output logic                 rsp_err,
  output logic                 psel,
  output logic                 penable,
  output logic                 pwrite,
  output logic [addrWidth-1:0] paddr,
  output logic [dataWidth-1:0] pwdata,
  input  logic [dataWidth-1:0] prdata,
  input  logic                 pready,
  input  logic                 interupt,
  input  logic                 irq_clr,
  output logic                 irq_flag,
  output logic                 busy
);

  localparam int unsigned CmdW = 1 + addrWidth + dataWidth;
  // Abort fires in the ACCESS cycle whose count equals this, i.e. the last allowed cycle.
  localparam logic [to_width-1:0] ToLimit = to_width'(timeout_cycles - 1);

  logic            fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_next_valid;
  logic [CmdW-1:0] fifo_head, fifo_next;

  apb_state_e           state_q, state_d;
  logic                 psel_q, psel_d;
  logic                 penable_q, penable_d;
  logic                 pwrite_q, pwrite_d;
  logic [addrWidth-1:0] paddr_q, paddr_d;
  logic [dataWidth-1:0] pwdata_q, pwdata_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [dataWidth-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [to_width-1:0]  to_cnt_q, to_cnt_d;
  logic                 xfer_done, xfer_abort;
  logic                 intr_prev_q, intr_prev_d;
  logic                 irq_flag_q, irq_flag_d;

  assign cmd_ready = !fifo_full;
  assign fifo_push = cmd_valid && !fifo_full;

  apb_cmd_fifo #(
    .Width(CmdW),
    .Depth(fifo_depth)
  ) u_fifo (
    .clk_i       (clk),
    .rst_i       (rst),
    .push_i      (fifo_push),
    .push_data_i ({cmd_write, cmd_addr, cmd_wdata}),
    .pop_i       (fifo_pop),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (fifo_head),
    .next_valid_o(fifo_next_valid),
    .next_data_o (fifo_next)
  );

  // Transfer sequencing: next state, registered APB outputs, response and timeout.
  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    to_cnt_d    = to_cnt_q;
    fifo_pop    = 1'b0;
    xfer_done   = 1'b0;
    xfer_abort  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d                       = SETUP;
          psel_d                        = 1'b1;
          penable_d                     = 1'b0;
          {pwrite_d, paddr_d, pwdata_d} = fifo_head;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
        to_cnt_d  = '0;
      end
      ACCESS: begin
        xfer_done  = pready;
        xfer_abort = !pready && (to_cnt_q == ToLimit);
        if (!pready && !xfer_abort) begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
        if (xfer_done || xfer_abort) begin
          fifo_pop    = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_err_d   = xfer_abort;
          rsp_rdata_d = (xfer_done && !pwrite_q) ? prdata : '0;
          penable_d   = 1'b0;
          if (fifo_next_valid) begin
            // Back-to-back: psel stays high, next command loaded straight into SETUP.
            state_d                       = SETUP;
            {pwrite_d, paddr_d, pwdata_d} = fifo_next;
          end else begin
            state_d = IDLE;
            psel_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  // FSM and all registered outputs; reset drops the bus immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      to_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

  // Sticky interrupt: a rising edge beats a simultaneous clear.
  always_comb begin
    intr_prev_d = interupt;
    irq_flag_d  = irq_flag_q;
    if (interupt && !intr_prev_q) begin
      irq_flag_d = 1'b1;
    end else if (irq_clr) begin
      irq_flag_d = 1'b0;
    end
  end

  // Interrupt history and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      intr_prev_q <= 1'b0;
      irq_flag_q  <= 1'b0;
    end else begin
      intr_prev_q <= intr_prev_d;
      irq_flag_q  <= irq_flag_d;
    end
  end

  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign irq_flag  = irq_flag_q;
  assign busy      = !fifo_empty || (state_q != IDLE);

endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: directed scenarios plus a randomized run against a
// transaction-level model (command queue, APB completer, expected responses).
module tb_apb_cmd_master;

  localparam int unsigned AW = 9;
  localparam int unsigned DW = 91;
  localparam int unsigned TO = 255;

  typedef struct packed {
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } cmd_t;

  logic          clk, rst;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata, prdata;
  logic          pready;
  logic          interupt, irq_clr, irq_flag, busy;

  int vectors     = 0;
  int miscompares = 0;

  apb_cmd_master #(
    .addrWidth     (AW),
    .dataWidth     (DW),
    .fifo_depth    (2),
    .timeout_cycles(TO),
    .to_width      (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .paddr    (paddr),
    .pwdata   (pwdata),
    .prdata   (prdata),
    .pready   (pready),
    .interupt (interupt),
    .irq_clr  (irq_clr),
    .irq_flag (irq_flag),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[DW-1:0];
  endfunction

  task automatic push_one(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL push_ready: got %0b want 1", cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    vectors++;
    if ({psel, penable, pwrite, rsp_valid, rsp_err, irq_flag, busy} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b want 0000000",
               {psel, penable, pwrite, rsp_valid, rsp_err, irq_flag, busy});
    end
    vectors++;
    if ({paddr, pwdata, rsp_rdata} !== '0) begin
      miscompares++;
      $display("FAIL reset_data: paddr %h pwdata %h rdata %h want 0", paddr, pwdata, rsp_rdata);
    end
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: got %0b want 1", cmd_ready);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_write();
    pready = 1'b1;
    push_one(1'b1, 9'd2, 91'd1);
    vectors++;
    if ({psel, busy} !== 2'b01) begin
      miscompares++;
      $display("FAIL wr_n0: psel,busy got %b want 01", {psel, busy});
    end
    tick();
    vectors++;
    if ({psel, penable, pwrite, paddr, pwdata} !== {3'b101, 9'd2, 91'd1}) begin
      miscompares++;
      $display("FAIL wr_setup: psel %0b pen %0b pwrite %0b paddr %h pwdata %h want 1 0 1 2 1",
               psel, penable, pwrite, paddr, pwdata);
    end
    tick();
    vectors++;
    if ({psel, penable, rsp_valid, paddr} !== {3'b110, 9'd2}) begin
      miscompares++;
      $display("FAIL wr_access: psel %0b pen %0b rsp %0b paddr %h want 1 1 0 2",
               psel, penable, rsp_valid, paddr);
    end
    tick();
    vectors++;
    if ({rsp_valid, rsp_err, psel, penable} !== 4'b1000 || rsp_rdata !== '0) begin
      miscompares++;
      $display("FAIL wr_rsp: valid %0b err %0b psel %0b pen %0b rdata %h want 1 0 0 0 0",
               rsp_valid, rsp_err, psel, penable, rsp_rdata);
    end
    tick();
    vectors++;
    if ({rsp_valid, busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL wr_after: rsp_valid,busy got %b want 00", {rsp_valid, busy});
    end
    pready = 1'b0;
  endtask

  task automatic test_read_wait();
    pready = 1'b0;
    prdata = 91'h33;
    push_one(1'b0, 9'd0, '0);
    tick();
    tick();
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if ({psel, penable, pwrite, paddr, rsp_valid} !== {3'b110, 9'd0, 1'b0}) begin
        miscompares++;
        $display("FAIL rd_wait%0d: psel %0b pen %0b pwrite %0b paddr %h rsp %0b want 1 1 0 0 0",
                 k, psel, penable, pwrite, paddr, rsp_valid);
      end
      if (k == 3) begin
        pready = 1'b1;
        prdata = 91'h5A;
      end
      tick();
    end
    pready = 1'b0;
    prdata = '0;
    vectors++;
    if ({rsp_valid, rsp_err, penable} !== 3'b100 || rsp_rdata !== 91'h5A) begin
      miscompares++;
      $display("FAIL rd_rsp: valid %0b err %0b pen %0b rdata %h want 1 0 0 5a",
               rsp_valid, rsp_err, penable, rsp_rdata);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] ba [3];
    logic [DW-1:0] bd [3];
    logic          s_psel [9];
    logic          s_pen  [9];
    logic          s_rdy  [9];
    logic          s_rsp  [9];
    logic          s_wr   [9];
    logic [AW-1:0] s_addr [9];
    logic [DW-1:0] s_wd   [9];
    int            idx;
    logic          pushed;
    ba = '{9'd10, 9'd11, 9'd13};
    bd = '{91'd1, 91'h11, 91'd10};
    idx = 0;
    pready = 1'b1;
    for (int cyc = 0; cyc < 9; cyc++) begin
      s_psel[cyc] = psel;
      s_pen[cyc]  = penable;
      s_rdy[cyc]  = cmd_ready;
      s_rsp[cyc]  = rsp_valid;
      s_wr[cyc]   = pwrite;
      s_addr[cyc] = paddr;
      s_wd[cyc]   = pwdata;
      if (idx < 3) begin
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = ba[idx];
        cmd_wdata = bd[idx];
      end else begin
        cmd_valid = 1'b0;
      end
      pushed = cmd_valid && cmd_ready;
      tick();
      if (pushed) idx++;
    end
    cmd_valid = 1'b0;
    pready    = 1'b0;
    for (int cyc = 2; cyc < 8; cyc++) begin
      vectors++;
      if ({s_psel[cyc], s_pen[cyc]} !== {1'b1, 1'(cyc % 2)}) begin
        miscompares++;
        $display("FAIL b2b_bus c%0d: psel %0b pen %0b want 1 %0d",
                 cyc, s_psel[cyc], s_pen[cyc], cyc % 2);
      end
    end
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if ({s_wr[2+2*k], s_addr[2+2*k], s_wd[2+2*k]} !== {1'b1, ba[k], bd[k]}) begin
        miscompares++;
        $display("FAIL b2b_cmd%0d: pwrite %0b paddr %h pwdata %h want 1 %h %h",
                 k, s_wr[2+2*k], s_addr[2+2*k], s_wd[2+2*k], ba[k], bd[k]);
      end
    end
    vectors++;
    if ({s_rdy[2], s_rdy[3], s_rdy[4]} !== 3'b001) begin
      miscompares++;
      $display("FAIL b2b_ready: got %b want 001", {s_rdy[2], s_rdy[3], s_rdy[4]});
    end
    vectors++;
    if ({s_rsp[4], s_rsp[5], s_rsp[6], s_rsp[7], s_rsp[8], s_psel[8]} !== 6'b101010) begin
      miscompares++;
      $display("FAIL b2b_rsp: got %b want 101010",
               {s_rsp[4], s_rsp[5], s_rsp[6], s_rsp[7], s_rsp[8], s_psel[8]});
    end
    tick();
  endtask

  task automatic test_timeout();
    int cnt;
    pready = 1'b0;
    prdata = 91'h7F;
    push_one(1'b0, 9'd5, '0);
    for (int i = 0; i < 10 && !penable; i++) tick();
    cnt = 0;
    while (penable && cnt < 400) begin
      cnt++;
      tick();
    end
    vectors++;
    if (cnt != TO) begin
      miscompares++;
      $display("FAIL to_cycles: got %0d want %0d", cnt, TO);
    end
    vectors++;
    if ({rsp_valid, rsp_err, psel, penable} !== 4'b1100 || rsp_rdata !== '0) begin
      miscompares++;
      $display("FAIL to_rsp: valid %0b err %0b psel %0b pen %0b rdata %h want 1 1 0 0 0",
               rsp_valid, rsp_err, psel, penable, rsp_rdata);
    end
    tick();
    vectors++;
    if ({rsp_valid, busy, psel} !== 3'b000) begin
      miscompares++;
      $display("FAIL to_idle: rsp,busy,psel got %b want 000", {rsp_valid, busy, psel});
    end
    prdata = '0;
  endtask

  task automatic test_random();
    cmd_t          q[$];
    cmd_t          c;
    logic          exp_rsp, complete, pushed, prev_setup;
    logic [DW-1:0] exp_rdata;
    logic [31:0]   r;
    int            wait_cnt;
    exp_rsp    = 1'b0;
    exp_rdata  = '0;
    prev_setup = 1'b0;
    wait_cnt   = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      vectors++;
      if (rsp_valid !== exp_rsp) begin
        miscompares++;
        $display("FAIL rnd_rsp_valid c%0d: got %0b want %0b", cyc, rsp_valid, exp_rsp);
      end
      if (exp_rsp) begin
        vectors++;
        if ({rsp_err, rsp_rdata} !== {1'b0, exp_rdata}) begin
          miscompares++;
          $display("FAIL rnd_rsp_data c%0d: err %0b rdata %h want 0 %h",
                   cyc, rsp_err, rsp_rdata, exp_rdata);
        end
      end
      vectors++;
      if (cmd_ready !== (q.size() < 2) || busy !== (q.size() != 0)) begin
        miscompares++;
        $display("FAIL rnd_flow c%0d: ready %0b busy %0b with %0d queued",
                 cyc, cmd_ready, busy, q.size());
      end
      if (prev_setup) begin
        vectors++;
        if ({psel, penable} !== 2'b11) begin
          miscompares++;
          $display("FAIL rnd_setup_access c%0d: psel %0b pen %0b want 1 1", cyc, psel, penable);
        end
      end
      if (psel) begin
        vectors++;
        if (q.size() == 0 || {pwrite, paddr, pwdata} !== {q[0].w, q[0].a, q[0].d}) begin
          miscompares++;
          $display("FAIL rnd_apb c%0d: pwrite %0b paddr %h pwdata %h queued %0d",
                   cyc, pwrite, paddr, pwdata, q.size());
        end
      end
      prev_setup = psel && !penable;
      r        = $urandom();
      prdata   = rand_data();
      complete = 1'b0;
      if (psel && penable) begin
        pready   = (r[1:0] != 2'b00) || (wait_cnt >= 6);
        wait_cnt = pready ? 0 : wait_cnt + 1;
        complete = pready;
      end else begin
        pready = r[2];
      end
      if (cyc < 550) begin
        cmd_valid = r[3] | r[4];
        cmd_write = r[5];
        cmd_addr  = r[16:8];
        cmd_wdata = rand_data();
      end else begin
        cmd_valid = 1'b0;
      end
      pushed  = cmd_valid && cmd_ready;
      c       = {cmd_write, cmd_addr, cmd_wdata};
      exp_rsp = complete && (q.size() > 0);
      if (exp_rsp) exp_rdata = q[0].w ? '0 : prdata;
      tick();
      if (complete && q.size() > 0) void'(q.pop_front());
      if (pushed) q.push_back(c);
    end
    cmd_valid = 1'b0;
    pready    = 1'b0;
    vectors++;
    if (q.size() != 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rnd_drain: %0d commands left, busy %0b", q.size(), busy);
    end
  endtask

  task automatic test_reset_mid();
    pready = 1'b0;
    push_one(1'b1, 9'd3, 91'h3);
    push_one(1'b0, 9'd4, '0);
    tick();
    vectors++;
    if ({psel, penable, busy} !== 3'b111) begin
      miscompares++;
      $display("FAIL rstmid_pre: psel,pen,busy got %b want 111", {psel, penable, busy});
    end
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if ({psel, penable, busy} !== 3'b000) begin
      miscompares++;
      $display("FAIL rstmid_async: psel,pen,busy got %b want 000", {psel, penable, busy});
    end
    tick();
    rst    = 1'b0;
    pready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if ({rsp_valid, psel, busy} !== 3'b000) begin
        miscompares++;
        $display("FAIL rstmid_after%0d: rsp,psel,busy got %b want 000", i,
                 {rsp_valid, psel, busy});
      end
      tick();
    end
    pready = 1'b0;
  endtask

  task automatic test_irq();
    interupt = 1'b0;
    irq_clr  = 1'b0;
    tick();
    vectors++;
    if (irq_flag !== 1'b0) begin
      miscompares++;
      $display("FAIL irq_idle: got %0b want 0", irq_flag);
    end
    interupt = 1'b1;
    irq_clr  = 1'b1;
    tick();
    vectors++;
    if (irq_flag !== 1'b1) begin
      miscompares++;
      $display("FAIL irq_set_wins: got %0b want 1", irq_flag);
    end
    tick();
    vectors++;
    if (irq_flag !== 1'b0) begin
      miscompares++;
      $display("FAIL irq_clear: got %0b want 0", irq_flag);
    end
    irq_clr = 1'b0;
    tick();
    vectors++;
    if (irq_flag !== 1'b0) begin
      miscompares++;
      $display("FAIL irq_level_no_set: got %0b want 0", irq_flag);
    end
    interupt = 1'b0;
    tick();
    interupt = 1'b1;
    tick();
    tick();
    vectors++;
    if (irq_flag !== 1'b1) begin
      miscompares++;
      $display("FAIL irq_sticky: got %0b want 1", irq_flag);
    end
    irq_clr = 1'b1;
    tick();
    vectors++;
    if (irq_flag !== 1'b0) begin
      miscompares++;
      $display("FAIL irq_clear2: got %0b want 0", irq_flag);
    end
    irq_clr  = 1'b0;
    interupt = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    prdata    = '0;
    pready    = 1'b0;
    interupt  = 1'b0;
    irq_clr   = 1'b0;
    test_reset();
    test_single_write();
    test_read_wait();
    test_back_to_back();
    test_timeout();
    test_random();
    test_reset_mid();
    test_irq();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/apb_cmd_master.md
APB_CMD_MASTER -- requirements
Module: apb_cmd_master

Interface
REQ-001 Parameters SHALL be: addrWidth, 9, APB address width; dataWidth, 91, APB data width; fifo_depth, 2, command buffer entries; timeout_cycles, 255, max ACCESS cycles before abort; to_width, 8, timeout counter width.
REQ-002 Clock and reset SHALL be: one clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  system clock, all logic on rising edge.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 cmd_valid  input  1  command offered; cmd_ready  output  1  command accepted when both high.
REQ-006 cmd_write  input  1  1=write, 0=read; cmd_addr  input  addrWidth  target register; cmd_wdata  input  dataWidth  write data.
REQ-007 rsp_valid  output  1  one-cycle response pulse; rsp_rdata  output  dataWidth  read data (0 for writes); rsp_err  output  1  transfer timed out.
REQ-008 psel, penable, pwrite  output  1 each; paddr  output  addrWidth; pwdata  output  dataWidth: APB requester side.
REQ-009 prdata  input  dataWidth; pready  input  1: APB completer response.
REQ-010 interupt  input  1  core done level; irq_clr  input  1  clears sticky flag; irq_flag  output  1  sticky captured rising edge of interupt.
REQ-011 busy  output  1  high while FIFO non-empty or FSM not IDLE.

Function
REQ-012 Commands SHALL be buffered in a fifo_depth-entry FIFO; cmd_ready = FIFO not full; push on cmd_valid&&cmd_ready.
REQ-013 Simultaneous push and pop on a full FIFO SHALL be rejected for the push (cmd_ready low when full, regardless of pop).
REQ-014 FSM states SHALL be IDLE, SETUP, ACCESS.
REQ-015 IDLE -> SETUP when FIFO non-empty; outputs for SETUP registered so psel=1, penable=0 in the first SETUP cycle.
REQ-016 SETUP -> ACCESS unconditionally after exactly one cycle; penable=1 in ACCESS.
REQ-017 paddr, pwrite, pwdata SHALL be loaded from FIFO head on entering SETUP and held stable through ACCESS.
REQ-018 In ACCESS with pready=1: transfer completes, FIFO pops, capture prdata for reads (0 for writes), rsp_valid=1 with rsp_err=0 in the next cycle.
REQ-019 After completion: go SETUP if FIFO still non-empty after the pop (back-to-back, psel stays 1, penable drops to 0), else IDLE (psel=0, penable=0).
REQ-020 Timeout counter SHALL clear on entering ACCESS and increment each ACCESS cycle with pready=0; on reaching timeout_cycles: abort, pop FIFO, rsp_valid=1 with rsp_err=1, rsp_rdata=0, next state per REQ-019.
REQ-021 pready SHALL be ignored outside ACCESS.
REQ-022 Minimum latency: command accepted at edge N -> SETUP at N+1 -> ACCESS at N+2 -> rsp_valid at N+3 when pready=1 in first ACCESS cycle.
REQ-023 irq_flag SHALL set on interupt rising edge (registered previous value); irq_clr clears; simultaneous set and clear -> set wins.
REQ-024 rsp_valid SHALL never be high for two consecutive cycles from the same transfer; no response backpressure.

Reset
REQ-025 On rst: FSM=IDLE, FIFO empty, psel=penable=pwrite=0, paddr=0, pwdata=0, rsp_valid=rsp_err=0, rsp_rdata=0, irq_flag=0, interupt history=0, timeout counter=0.
REQ-026 Reset mid-transfer SHALL drop psel/penable immediately (asynchronously) and discard all buffered commands; no response issued.

Structure
REQ-027 A shared package apb_cmd_pkg SHALL hold the FSM state enum (IDLE, SETUP, ACCESS) and the register-index enum (internal_status_reg … last_ram_addr_reg, values 0–13).
REQ-028 The FIFO SHALL be a separate sub-module apb_cmd_fifo (parameterised width, depth); FSM, timeout and irq logic stay in apb_cmd_master.

Verification
REQ-029 Write cent_1_reg (addr 2) data 1, pready tied 1 -> SETUP then ACCESS with paddr=2, pwdata=1, pwrite=1; rsp_valid at N+3, rsp_err=0.
REQ-030 Read addr 0, pready low 3 ACCESS cycles then high with prdata=0x5A -> penable held 4 cycles, paddr stable, rsp_rdata=0x5A.
REQ-031 Three back-to-back writes (addr 10 data 1, addr 11 data 0x11, addr 13 data 10), pready=1 -> psel never drops, penable pattern 0,1,0,1,0,1; third cmd_ready low until first pop.
REQ-032 pready held 0, timeout_cycles=255 -> abort after 255 ACCESS cycles, rsp_valid=1, rsp_err=1, rsp_rdata=0, FSM IDLE.
REQ-033 Assert rst during ACCESS with 2 commands buffered -> psel=penable=0 same cycle, busy=0, no rsp_valid afterwards.
REQ-034 interupt rises while irq_clr=1 same cycle -> irq_flag=1; irq_clr next cycle -> irq_flag=0.
